vec_result_collector: RTL and testbench

- Receiving end of the vec_alu lane output interface: gathers the per-lane result chunks (vd, reg_index, done-qualified valid) from up to 4 vec_alu lanes into one VLEN-bit destination vector.
- Hands the completed vector to the vector register file write port via a valid/ready handshake.
- Sits between the vec_alu lane array and the vector regfile writeback path.

---
 rtl/vec_result_collector.sv | 136 +++++++++++++
 tb/tb_vec_result_collector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_result_collector.sv
// Gathers per-lane vec_alu result chunks into one VLEN-bit destination vector
// and hands the finished vector to the regfile write port with a valid/ready handshake.
module vec_result_collector #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int MAX_LANES  = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [2:0]                vsew,
  input  logic [1:0]                nb_lanes,
  input  logic [MAX_LANES-1:0]      lane_valid,
  input  logic [MAX_LANES*64-1:0]   lane_vd,
  input  logic [MAX_LANES*10-1:0]   lane_idx,
  output logic [VLEN-1:0]           vd,
  output logic                      busy,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic                      err
);

  localparam int CNT_W = $clog2(VLEN / 8) + 1;

  typedef logic [VLEN-1:0]  vec_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, COLLECT, WB} state_t;

  state_t     state_q, state_d;
  vec_t       vd_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] sew_q, sew_d;
  logic [2:0] na_q, na_d;
  logic       err_d;

  // Chunk geometry derived from the latched element width.
  logic [2:0]  cw_log2;
  logic [9:0]  cw;
  logic [63:0] cw_mask;
  cnt_t        tot;

  always_comb begin
    cw_log2 = 3'(LANE_WIDTH);
    if ({1'b0, sew_q} + 3'd3 < 3'(LANE_WIDTH)) cw_log2 = {1'b0, sew_q} + 3'd3;
    cw      = 10'd1 << cw_log2;
    cw_mask = (64'd1 << cw) - 64'd1;
    tot     = cnt_t'(VLEN >> cw_log2);
  end

  logic [9:0]                  idx;
  logic                        legal;
  logic [MAX_LANES-1:0]        taken;
  logic [MAX_LANES-1:0][9:0]   taken_idx;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    vd_d      = vd;
    cnt_d     = cnt_q;
    sew_d     = sew_q;
    na_d      = na_q;
    err_d     = err;
    idx       = '0;
    legal     = 1'b0;
    taken     = '0;
    taken_idx = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (vsew <= 3'd3) begin
            vd_d    = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            sew_d   = vsew[1:0];
            na_d    = (nb_lanes == 2'd0) ? 3'd1 : (nb_lanes == 2'd1) ? 3'd2 : 3'd4;
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        // Lanes are visited in ascending order so the highest lane wins a shared index.
        for (int i = 0; i < MAX_LANES; i++) begin
          if (i < int'(na_q) && lane_valid[i]) begin
            idx   = lane_idx[i*10 +: 10];
            legal = ((idx & (cw - 10'd1)) == 10'd0) && (int'(idx) + int'(cw) <= VLEN);
            if (!legal || cnt_d >= tot) begin
              err_d = 1'b1;
            end else begin
              for (int j = 0; j < i; j++)
                if (taken[j] && taken_idx[j] == idx) err_d = 1'b1;
              taken[i]     = 1'b1;
              taken_idx[i] = idx;
              vd_d  = (vd_d & ~(vec_t'(cw_mask) << idx))
                    | (vec_t'(lane_vd[i*64 +: 64] & cw_mask) << idx);
              cnt_d = cnt_d + cnt_t'(1);
            end
          end
        end
        if (cnt_d == tot) state_d = WB;
      end

      WB: begin
        if (wb_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      vd      <= '0;
      cnt_q   <= '0;
      sew_q   <= '0;
      na_q    <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      vd      <= vd_d;
      cnt_q   <= cnt_d;
      sew_q   <= sew_d;
      na_q    <= na_d;
      err     <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign wb_valid = (state_q == WB);

endmodule

// File: tb/tb_vec_result_collector.sv
// Directed bench for vec_result_collector: one instance with 8-bit lanes and
// one with 64-bit lanes share the lane buses but have separate start pulses.
module tb_vec_result_collector;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start8, start64;
  logic [2:0]   vsew;
  logic [1:0]   nb_lanes;
  logic [3:0]   lane_valid;
  logic [255:0] lane_vd;
  logic [39:0]  lane_idx;
  logic         wb_ready;

  logic [127:0] vd8, vd64;
  logic         busy8, wbv8, err8;
  logic         busy64, wbv64, err64;

  vec_result_collector #(.VLEN(128), .LANE_WIDTH(3), .MAX_LANES(4)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .vsew(vsew), .nb_lanes(nb_lanes),
    .lane_valid(lane_valid), .lane_vd(lane_vd), .lane_idx(lane_idx),
    .vd(vd8), .busy(busy8), .wb_valid(wbv8), .wb_ready(wb_ready), .err(err8)
  );

  vec_result_collector #(.VLEN(128), .LANE_WIDTH(6), .MAX_LANES(4)) dut64 (
    .clk(clk), .resetn(resetn), .start(start64), .vsew(vsew), .nb_lanes(nb_lanes),
    .lane_valid(lane_valid), .lane_vd(lane_vd), .lane_idx(lane_idx),
    .vd(vd64), .busy(busy64), .wb_valid(wbv64), .wb_ready(wb_ready), .err(err64)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_dut8(input logic [2:0] sew, input logic [1:0] nb);
    start8 = 1'b1; vsew = sew; nb_lanes = nb;
    tick();
    start8 = 1'b0;
  endtask

  task automatic put(input int lane, input logic [63:0] data, input int idx);
    lane_valid[lane]        = 1'b1;
    lane_vd[lane*64 +: 64]  = data;
    lane_idx[lane*10 +: 10] = 10'(idx);
  endtask

  // Byte chunks lo..hi of v on lane 0, one per cycle, skipping chunk 'skip'.
  task automatic feed(input logic [127:0] v, input int lo, input int hi, input int skip);
    for (int k = lo; k <= hi; k++) begin
      if (k != skip) begin
        put(0, {56'd0, v[8*k +: 8]}, 8*k);
        tick();
      end
    end
    lane_valid = '0;
  endtask

  task automatic handshake8();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  localparam logic [127:0] V1 = 128'h3232eeeed0231467d02314673232eeee;
  localparam logic [127:0] V2 = 128'h0123456789abcdeffedcba9876543210;

  logic [127:0] exp_dup;

  initial begin
    resetn = 1'b0; start8 = 1'b0; start64 = 1'b0; vsew = '0; nb_lanes = '0;
    lane_valid = '0; lane_vd = '0; lane_idx = '0; wb_ready = 1'b0;
    tick(); tick();
    check("reset_vd", vd8, '0);
    check("reset_busy", busy8, 1'b0);
    check("reset_wb_valid", wbv8, 1'b0);
    check("reset_err", err8, 1'b0);
    resetn = 1'b1;
    tick();

    // Illegal element width: rejected with error, stays idle.
    start_dut8(3'd5, 2'd0);
    check("bad_vsew_err", err8, 1'b1);
    check("bad_vsew_busy", busy8, 1'b0);

    // Single 8-bit lane, 16 byte chunks.
    start_dut8(3'd0, 2'd0);
    check("t1_busy", busy8, 1'b1);
    check("t1_vd_clear", vd8, '0);
    check("t1_err_cleared", err8, 1'b0);
    feed(V1, 0, 14, -1);
    check("t1_no_wb_before_last", wbv8, 1'b0);
    feed(V1, 15, 15, -1);
    check("t1_wb_valid", wbv8, 1'b1);
    check("t1_vd", vd8, V1);
    check("t1_err", err8, 1'b0);
    handshake8();
    check("t1_wb_drop", wbv8, 1'b0);
    check("t1_idle", busy8, 1'b0);

    // vsew=2 clamps to 8-bit chunks; back-pressure with a start in WB.
    start_dut8(3'd2, 2'd0);
    feed(V2, 0, 15, -1);
    check("t2_wb_valid", wbv8, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("t2_hold_valid", wbv8, 1'b1);
      check("t2_hold_vd", vd8, V2);
    end
    handshake8();
    check("t2_wb_drop", wbv8, 1'b0);
    check("t2_idle", busy8, 1'b0);
    check("t2_vd_kept", vd8, V2);

    // Start after handshake clears vd; two active lanes.
    start_dut8(3'd0, 2'd1);
    check("t3_vd_clear", vd8, '0);
    check("t3_busy", busy8, 1'b1);
    put(2, 64'hff, 0);
    tick(); lane_valid = '0;
    check("inactive_lane_err", err8, 1'b0);
    check("inactive_lane_vd", vd8, '0);
    put(0, 64'h55, 4);
    tick(); lane_valid = '0;
    check("misaligned_err", err8, 1'b1);
    check("misaligned_vd", vd8, '0);
    feed(V1, 0, 14, -1);
    check("dropped_not_counted", wbv8, 1'b0);
    feed(V1, 15, 15, -1);
    check("t3_wb_valid", wbv8, 1'b1);
    check("t3_vd", vd8, V1);
    handshake8();

    // Two lanes at the same index: lane 1 wins, both counted.
    start_dut8(3'd0, 2'd1);
    check("dup_err_cleared", err8, 1'b0);
    put(0, 64'haa, 16);
    put(1, 64'hbb, 16);
    tick(); lane_valid = '0;
    check("dup_err", err8, 1'b1);
    check("dup_vd", vd8, 128'hbb << 16);
    feed(V1, 0, 14, 2);
    exp_dup = V1;
    exp_dup[127:120] = 8'h00;
    exp_dup[23:16]   = 8'hbb;
    check("dup_both_counted", wbv8, 1'b1);
    check("dup_final_vd", vd8, exp_dup);
    handshake8();

    // Asynchronous reset mid-collection.
    start_dut8(3'd0, 2'd0);
    feed(V1, 0, 4, -1);
    #2 resetn = 1'b0;
    #1;
    check("arst_vd", vd8, '0);
    check("arst_busy", busy8, 1'b0);
    check("arst_wb_valid", wbv8, 1'b0);
    check("arst_err", err8, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    start_dut8(3'd0, 2'd0);
    feed(V2, 0, 15, -1);
    check("post_rst_wb_valid", wbv8, 1'b1);
    check("post_rst_vd", vd8, V2);
    handshake8();

    // 64-bit lanes: two chunks in one cycle complete the vector.
    start64 = 1'b1; vsew = 3'd3; nb_lanes = 2'd1;
    tick();
    start64 = 1'b0;
    check("w64_busy", busy64, 1'b1);
    put(0, 64'hd12415683332eeee, 0);
    put(1, 64'h3332eeeed1241567, 64);
    tick(); lane_valid = '0;
    check("w64_wb_valid", wbv64, 1'b1);
    check("w64_vd", vd64, 128'h3332eeeed1241567d12415683332eeee);
    check("w64_err", err64, 1'b0);
    handshake8();
    check("w64_wb_drop", wbv64, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
